// File: rtl/mul_div_unit_pkg.sv
// Shared multiply/divide definitions: op codes decoded by the control unit
// and the default busy-cycle counts used by the EX-stage MDU.
package mdu_pkg;

    // Op codes carried from the decoder to the MDU
    localparam logic [3:0] MDU_NONE = 4'd0;
    localparam logic [3:0] MULT     = 4'd1;
    localparam logic [3:0] MULTU    = 4'd2;
    localparam logic [3:0] DIV      = 4'd3;
    localparam logic [3:0] DIVU     = 4'd4;
    localparam logic [3:0] MTHI     = 4'd5;
    localparam logic [3:0] MTLO     = 4'd6;
    localparam logic [3:0] MADD     = 4'd7;
    localparam logic [3:0] MADDU    = 4'd8;

    // Default busy-cycle counts
    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // Control state; RUN is simply "cycle counter non-zero"
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

endpackage

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO pair.
// Handshake: a one-cycle start strobe is accepted only while busy=0; busy is
// high for exactly the op's cycle count and falls on the edge that commits
// HI/LO. Starts while busy are dropped.
// Optional MDU_MADD_EN macro enables MADD/MADDU accumulate into {HI,LO}.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    logic [CNT_W-1:0] cnt, cnt_n;
    logic [31:0]      hi_n, lo_n;
    logic [31:0]      pend_hi, pend_lo, pend_hi_n, pend_lo_n;
    logic             pend_wr, pend_wr_n;
    logic             busy_n;
    mdu_state_e       state;

    logic [63:0] prod_s, prod_u;
    logic [31:0] quot_s, rem_s, quot_u, rem_u;
    logic        b_zero;

    // Full-width products and quotients from the operands presented this cycle
    always_comb begin
        prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        prod_u = {32'b0, A} * {32'b0, B};
        b_zero = (B == 32'd0);
        quot_s = b_zero ? 32'd0 : 32'($signed(A) / $signed(B));
        rem_s  = b_zero ? 32'd0 : 32'($signed(A) % $signed(B));
        quot_u = b_zero ? 32'd0 : A / B;
        rem_u  = b_zero ? 32'd0 : A % B;
    end

`ifdef MDU_MADD_EN
    logic [63:0] acc_s, acc_u;
    // Accumulate base is the HI/LO pair visible at the start edge
    always_comb begin
        acc_s = {HI, LO} + prod_s;
        acc_u = {HI, LO} + prod_u;
    end
`endif

    // Next-state: issue in IDLE, count down in RUN, commit on the 1->0 step
    always_comb begin
        cnt_n     = cnt;
        hi_n      = HI;
        lo_n      = LO;
        pend_hi_n = pend_hi;
        pend_lo_n = pend_lo;
        pend_wr_n = pend_wr;
        state     = (cnt == '0) ? ST_IDLE : ST_RUN;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    case (op)
                        MULT: begin
                            cnt_n                  = CNT_W'(MULT_CYCLES);
                            {pend_hi_n, pend_lo_n} = prod_s;
                            pend_wr_n              = 1'b1;
                        end
                        MULTU: begin
                            cnt_n                  = CNT_W'(MULT_CYCLES);
                            {pend_hi_n, pend_lo_n} = prod_u;
                            pend_wr_n              = 1'b1;
                        end
                        DIV: begin
                            cnt_n     = CNT_W'(DIV_CYCLES);
                            pend_hi_n = rem_s;
                            pend_lo_n = quot_s;
                            pend_wr_n = !b_zero;
                        end
                        DIVU: begin
                            cnt_n     = CNT_W'(DIV_CYCLES);
                            pend_hi_n = rem_u;
                            pend_lo_n = quot_u;
                            pend_wr_n = !b_zero;
                        end
                        MTHI: hi_n = A;
                        MTLO: lo_n = A;
`ifdef MDU_MADD_EN
                        MADD: begin
                            cnt_n                  = CNT_W'(MULT_CYCLES);
                            {pend_hi_n, pend_lo_n} = acc_s;
                            pend_wr_n              = 1'b1;
                        end
                        MADDU: begin
                            cnt_n                  = CNT_W'(MULT_CYCLES);
                            {pend_hi_n, pend_lo_n} = acc_u;
                            pend_wr_n              = 1'b1;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                cnt_n = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1) && pend_wr) begin
                    hi_n = pend_hi;
                    lo_n = pend_lo;
                end
            end
            default: ;
        endcase
        busy_n = (cnt_n != '0);
    end

    // State registers; reset aborts any in-flight op without committing
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            busy    <= 1'b0;
            HI      <= 32'd0;
            LO      <= 32'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_wr <= 1'b0;
        end else begin
            cnt     <= cnt_n;
            busy    <= busy_n;
            HI      <= hi_n;
            LO      <= lo_n;
            pend_hi <= pend_hi_n;
            pend_lo <= pend_lo_n;
            pend_wr <= pend_wr_n;
        end
    end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
Multi-cycle multiply/divide unit in the EX stage of the pipelined MIPS core.
- Consumes forwarded source operands (register-file read data after forwarding muxes) on mult/multu/div/divu/mthi/mtlo.
- Holds the architectural HI/LO registers and presents them for mfhi/mflo, whose result travels down the pipe to the register-file write port.
- Exposes busy so the hazard unit stalls later MDU instructions in ID.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (≥1)
DIV_CYCLES, 10, busy cycles for div/divu (≥1)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high
start  input  1  one-cycle strobe: issue op in this cycle
op  input  4  operation code (shared package)
A  input  32  operand rs (forwarded)
B  input  32  operand rt (forwarded)
busy  output  1  registered; high while an operation is in flight
HI  output  32  architectural HI register
LO  output  32  architectural LO register

Behaviour:
- Reset: on a clk edge with reset=1, HI=0, LO=0, busy=0 and the cycle counter is cleared. Any in-flight op is aborted; its result is never committed.
- Ops: MDU_NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO; MADD, MADDU only under the optional feature. Undefined codes are treated as MDU_NONE.
- States: IDLE, RUN.
  - IDLE: start=1 with a mult/div op moves to RUN. The counter loads MULT_CYCLES or DIV_CYCLES. The full 64-bit result is computed from A/B sampled at this edge and held in pending_hi/pending_lo.
  - RUN: the counter decrements each edge. On the edge where it goes 1→0, pending values are written to HI/LO, busy falls, and the state returns to IDLE.
- Latency: start sampled at edge T → busy=1 for exactly N cycles after T. HI/LO hold the new values from edge T+N, coincident with busy falling.
- mthi/mtlo: start=1 in IDLE writes A to HI or LO at that edge. No busy cycles.
- Arithmetic:
  - mult: signed 32×32→64, HI = upper half, LO = lower half.
  - multu: unsigned 32×32→64, same split.
  - div: signed; LO = quotient truncated toward zero, HI = remainder with the sign of the dividend.
  - divu: unsigned quotient/remainder.
- Divide by zero (B=0): op still takes DIV_CYCLES; HI/LO remain unchanged at commit.
- start=1 while busy=1: ignored, including mthi/mtlo. The hazard unit guarantees this does not occur; the ignore rule is a defined fallback.
- HI/LO outputs during RUN show the old values.
- start=1 with MDU_NONE: no effect.
- Reset asserted together with start: reset wins; no op is accepted.

Optional Feature:
MDU_MADD_EN
- Defined:
  - op MADD adds the signed A×B product to the 64-bit {HI,LO}, wrapping mod 2^64.
  - op MADDU adds the unsigned product, wrapping mod 2^64.
  - Both use MULT_CYCLES.
  - The accumulate base is {HI,LO} sampled at the start edge.
- Undefined: the MADD/MADDU codes are treated as MDU_NONE; no accumulate adder is synthesised.

Decomposition:
- Shared package mdu_pkg holds:
  - the op code constants (MDU_NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MADD=7, MADDU=8);
  - the default cycle-count constants.
- The decoder in the control unit uses the same package.
- No sub-module: arithmetic and the counter live in one module. The state is a single counter; RUN ⇔ counter≠0.

Test Plan:
- mult, A=0xFFFFFFFF, B=0x00000002 → busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- multu, same operands → HI=0x00000001, LO=0xFFFFFFFE; HI/LO still show previous values during busy cycles 1–4.
- div, A=7, B=0xFFFFFFFE (−2) → busy 10 cycles; then LO=0xFFFFFFFD, HI=0x00000001. divu, A=0x80000000, B=3 → LO=0x2AAAAAAA, HI=0x00000002.
- mthi A=0x12345678, then divu with B=0 → HI=0x12345678 immediately and still after 10 busy cycles; LO unchanged.
- Issue mult; assert start with mtlo A=0xDEAD at busy cycle 2 → mtlo ignored; LO=mult result. Assert reset at busy cycle 3 → next edge HI=LO=0, busy=0, no later commit.
- With MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, then maddu A=1, B=1 → HI=0x00000001, LO=0x00000000. Without the macro, the same stimulus leaves HI/LO unchanged and busy stays 0.
